// File: rtl/subleq_memory.sv
// Memory responder for the subleq core: zero-fills after reset, accepts a loader image, then serves the core.
// Optional build macro WRITE_FORWARD_EN: same-address write forwards the written value to data (read-after-write).
module subleq_memory #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [ADDR_WIDTH-1:0]          address_read,
   output logic [DATA_WIDTH-1:0]          data,
   input  logic [DATA_WIDTH+ADDR_WIDTH-1:0] address_write,
   input  logic                           write_strobe,
   input  logic                           load_valid,
   output logic                           load_ready,
   input  logic [ADDR_WIDTH-1:0]          load_addr,
   input  logic [DATA_WIDTH-1:0]          load_data,
   input  logic                           load_done,
   output logic                           run,
   output logic [15:0]                    write_count
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_e;

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  clear_ptr_q, clear_ptr_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   load_ready_q, load_ready_d;
   logic                   run_q, run_d;
   logic [CNT_W-1:0]       count_q, count_d;

   logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
   logic                   mem_we;
   logic [ADDR_WIDTH-1:0]  mem_wa;
   logic [DATA_WIDTH-1:0]  mem_wd;

   // State register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= S_CLEAR;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CLEAR: if (clear_ptr_q == ADDR_WIDTH'(DEPTH - 1)) state_d = S_LOAD;
         S_LOAD:  if (load_done) state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         default: state_d = S_CLEAR;
      endcase
   end

   // Output and memory-port logic
   always_comb begin
      data_d       = '0;
      load_ready_d = (state_d == S_LOAD);
      run_d        = (state_d == S_RUN);
      count_d      = count_q;
      clear_ptr_d  = clear_ptr_q;
      mem_we       = 1'b0;
      mem_wa       = '0;
      mem_wd       = '0;
      case (state_q)
         S_CLEAR: begin
            mem_we      = 1'b1;
            mem_wa      = clear_ptr_q;
            clear_ptr_d = clear_ptr_q + ADDR_WIDTH'(1);
         end
         S_LOAD: begin
            if (load_valid && load_ready_q) begin
               mem_we = 1'b1;
               mem_wa = load_addr;
               mem_wd = load_data;
            end
         end
         S_RUN: begin
            data_d = mem_q[address_read];
            if (write_strobe) begin
               mem_we = 1'b1;
               mem_wa = address_write[ADDR_WIDTH-1:0];
               mem_wd = address_write[DATA_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
               if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
`ifdef WRITE_FORWARD_EN
               if (mem_wa == address_read) data_d = mem_wd;
`endif
            end
         end
         default: ;
      endcase
   end

   // Registered outputs and clear pointer
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         clear_ptr_q  <= '0;
         data_q       <= '0;
         load_ready_q <= 1'b0;
         run_q        <= 1'b0;
         count_q      <= '0;
      end else begin
         clear_ptr_q  <= clear_ptr_d;
         data_q       <= data_d;
         load_ready_q <= load_ready_d;
         run_q        <= run_d;
         count_q      <= count_d;
      end
   end

   // Storage has no reset; the CLEAR phase zero-fills it
   always_ff @(posedge clock) begin
      if (mem_we) mem_q[mem_wa] <= mem_wd;
   end

   assign data        = data_q;
   assign load_ready  = load_ready_q;
   assign run         = run_q;
   assign write_count = count_q;

endmodule

// File: tb/tb_subleq_memory.sv
// Directed bench for subleq_memory with a read-data scoreboard and a reference memory model.
module tb_subleq_memory;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  address_read = '0;
   logic [7:0]  data;
   logic [15:0] address_write = '0;
   logic        write_strobe = 1'b0;
   logic        load_valid = 1'b0;
   logic        load_ready;
   logic [7:0]  load_addr = '0;
   logic [7:0]  load_data = '0;
   logic        load_done = 1'b0;
   logic        run;
   logic [15:0] write_count;

   int total = 0;
   int bad   = 0;

   logic [7:0]  model [256];
   logic [7:0]  sb [$];
   logic [15:0] cnt_m;

`ifdef WRITE_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   subleq_memory dut (
      .clock(clock), .reset_n(reset_n),
      .address_read(address_read), .data(data),
      .address_write(address_write), .write_strobe(write_strobe),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
      .run(run), .write_count(write_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      for (int i = 0; i < 256; i++) model[i] = 8'h00;
      cnt_m = 16'h0000;
      sb.delete();
   endtask

   // 256 cycles of zero-fill, loader flags must stay low until the last one
   task automatic clear_phase();
      for (int i = 1; i <= 256; i++) begin
         @(posedge clock); #1;
         check("clear_flags", 16'({run, load_ready}), (i == 256) ? 16'h0001 : 16'h0000);
         check("clear_data", 16'(data), 16'h0000);
      end
   endtask

   task automatic load_word(input logic v, input logic [7:0] a, input logic [7:0] d, input logic done);
      load_valid = v; load_addr = a; load_data = d; load_done = done;
      if (v) model[a] = d;
      @(posedge clock); #1;
      check("load_run", 16'(run), done ? 16'h0001 : 16'h0000);
      check("load_ready", 16'(load_ready), done ? 16'h0000 : 16'h0001);
      check("load_data_held", 16'(data), 16'h0000);
      load_valid = 1'b0; load_done = 1'b0;
   endtask

   // One RUN cycle: optional write, optional scoreboarded read, optional count check
   task automatic cyc(input logic [7:0] ra, input logic ws, input logic [15:0] aw,
                      input bit chk, input bit chk_cnt);
      logic [7:0] e;
      address_read = ra; write_strobe = ws; address_write = aw;
      if (chk) sb.push_back((FWD && ws && aw[7:0] == ra) ? aw[15:8] : model[ra]);
      if (ws) begin
         model[aw[7:0]] = aw[15:8];
         if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
      end
      @(posedge clock); #1;
      write_strobe = 1'b0;
      if (chk) begin
         e = sb.pop_front();
         check("read_data", 16'(data), 16'(e));
      end
      if (chk_cnt) check("write_count", write_count, cnt_m);
   endtask

   initial begin
      reset_model();
      #1;
      check("reset_flags", 16'({run, load_ready}), 16'h0000);
      check("reset_data", 16'(data), 16'h0000);
      check("reset_count", write_count, 16'h0000);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;

      clear_phase();

      // Image, with a rewrite of address 5 and a word presented alongside load_done
      load_word(1'b1, 8'h00, 8'h03, 1'b0);
      load_word(1'b0, 8'h40, 8'hEE, 1'b0);
      load_word(1'b1, 8'h01, 8'h04, 1'b0);
      load_word(1'b1, 8'h02, 8'h07, 1'b0);
      load_word(1'b1, 8'h05, 8'hAA, 1'b0);
      load_word(1'b1, 8'h05, 8'hBB, 1'b0);
      load_word(1'b1, 8'h06, 8'h66, 1'b1);

      cyc(8'h01, 1'b0, 16'h0000, 1'b1, 1'b1);
      cyc(8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
      cyc(8'h02, 1'b0, 16'h0000, 1'b1, 1'b0);
      cyc(8'h05, 1'b0, 16'h0000, 1'b1, 1'b0);
      cyc(8'h06, 1'b0, 16'h0000, 1'b1, 1'b0);
      cyc(8'h40, 1'b0, 16'h0000, 1'b1, 1'b0);
      cyc(8'h99, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Loader inputs ignored in RUN
      load_valid = 1'b1; load_addr = 8'h00; load_data = 8'hFF; load_done = 1'b1;
      cyc(8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);
      check("run_ready_low", 16'(load_ready), 16'h0000);
      load_valid = 1'b0; load_done = 1'b0;
      cyc(8'h00, 1'b0, 16'h0000, 1'b1, 1'b0);

      cyc(8'h00, 1'b1, 16'h5A10, 1'b0, 1'b1);
      cyc(8'h10, 1'b0, 16'h0000, 1'b1, 1'b1);

      // Same-address collision, then a following read
      cyc(8'h20, 1'b1, 16'hC320, 1'b1, 1'b1);
      cyc(8'h20, 1'b0, 16'h0000, 1'b1, 1'b0);
      check("fwd_settled", 16'(data), 16'h00C3);

      // Different addresses in the same cycle are independent
      cyc(8'h05, 1'b1, 16'h7730, 1'b1, 1'b1);
      cyc(8'h30, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Asynchronous reset mid-RUN, between edges
      #2 reset_n = 1'b0;
      #1;
      check("async_run", 16'(run), 16'h0000);
      check("async_data", 16'(data), 16'h0000);
      check("async_count", write_count, 16'h0000);
      check("async_ready", 16'(load_ready), 16'h0000);
      reset_model();
      @(posedge clock); #1 reset_n = 1'b1;
      clear_phase();
      load_word(1'b1, 8'h11, 8'h99, 1'b1);
      cyc(8'h10, 1'b0, 16'h0000, 1'b1, 1'b1);
      cyc(8'h11, 1'b0, 16'h0000, 1'b1, 1'b0);
      cyc(8'h20, 1'b0, 16'h0000, 1'b1, 1'b0);

      // Saturation of write_count
      for (int i = 0; cnt_m != 16'hFFFE; i++)
         cyc(8'h00, 1'b1, {8'(i), 8'hF0}, 1'b0, 1'b0);
      check("count_fffe", write_count, 16'hFFFE);
      cyc(8'hF0, 1'b1, 16'h12F1, 1'b1, 1'b1);
      check("count_ffff", write_count, 16'hFFFF);
      cyc(8'hF1, 1'b1, 16'h34F2, 1'b1, 1'b1);
      cyc(8'hF2, 1'b1, 16'h56F3, 1'b1, 1'b1);
      check("count_stays", write_count, 16'hFFFF);
      cyc(8'hF3, 1'b0, 16'h0000, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
